// File: rtl/mipi_dphy_tx_pkg.sv
// rtl/mipi_dphy_tx_pkg.sv - shared types, constants and lane helpers for the D-PHY TX lane controller
package mipi_dphy_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LPX,
        ST_PREP,
        ST_HS_ZERO,
        ST_SYNC,
        ST_DATA,
        ST_TRAIL,
        ST_EXIT
    } tx_state_t;

    localparam int         NUM_LANES = 4;
    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    // LP line codes as {p, n}
    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    // Lane 0 occupies the most significant byte of a beat.
    function automatic logic [7:0] lane_byte(input logic [31:0] word, input int lane);
        return word[8*(NUM_LANES-1-lane) +: 8];
    endfunction

    // Trailer: each lane repeats the inverse of the final bit it sent (bit 7, as
    // bytes go out LSB first).
    function automatic logic [31:0] trail_word(input logic [31:0] word);
        logic [31:0] t;
        logic [7:0]  b;
        t = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            b = lane_byte(word, l);
            t[8*(NUM_LANES-1-l) +: 8] = {8{~b[7]}};
        end
        return t;
    endfunction

endpackage

// File: rtl/mipi_tx_timer.sv
// rtl/mipi_tx_timer.sv - 8-bit loadable down-counter shared by the timed burst states
// Ports: clk, rst_n (async, active-low); load/value reload the counter;
// done is high while the counter sits at zero.
module mipi_tx_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] value,
    output logic       done
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign done = (count == 8'd0);

endmodule

// File: rtl/mipi_dphy_tx_lane_ctrl.sv
// rtl/mipi_dphy_tx_lane_ctrl.sv - four-lane D-PHY HS burst sequencer (LP request, HS-zero, sync, payload, trail, exit)
// Ports: I_clk/I_rst_n clock and async active-low reset; I_hs_req burst request;
// I_data/I_data_valid/I_last/O_data_ready payload stream; O_lptx_valid/p/n LP driver;
// O_hs_en/O_hs_data HS driver; O_busy burst in progress; O_underflow payload ran dry.
module mipi_dphy_tx_lane_ctrl
    import mipi_dphy_tx_pkg::*;
#(
    parameter int T_LPX        = 2,
    parameter int T_HS_PREPARE = 2,
    parameter int T_HS_ZERO    = 6,
    parameter int T_HS_TRAIL   = 3,
    parameter int T_HS_EXIT    = 4
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_hs_req,
    input  logic [31:0] I_data,
    input  logic        I_data_valid,
    input  logic        I_last,
    output logic        O_data_ready,
    output logic        O_lptx_valid,
    output logic        O_lptx_p,
    output logic        O_lptx_n,
    output logic        O_hs_en,
    output logic [31:0] O_hs_data,
    output logic        O_busy,
    output logic        O_underflow
);

    // Timer is loaded with P-1 so each timed state lasts exactly P cycles.
    localparam logic [7:0] LPX_LOAD   = 8'(T_LPX - 1);
    localparam logic [7:0] PREP_LOAD  = 8'(T_HS_PREPARE - 1);
    localparam logic [7:0] ZERO_LOAD  = 8'(T_HS_ZERO - 1);
    localparam logic [7:0] TRAIL_LOAD = 8'(T_HS_TRAIL - 1);
    localparam logic [7:0] EXIT_LOAD  = 8'(T_HS_EXIT - 1);

    tx_state_t   state, state_n;
    logic        tmr_load, tmr_done;
    logic [7:0]  tmr_value;
    logic        accept;
    logic        lptx_valid_n, hs_en_n, ready_n, busy_n;
    logic [1:0]  lp_code_n;
    logic [31:0] hs_data_n;

    mipi_tx_timer u_timer (
        .clk   (I_clk),
        .rst_n (I_rst_n),
        .load  (tmr_load),
        .value (tmr_value),
        .done  (tmr_done)
    );

    assign accept      = O_data_ready & I_data_valid;
    // Ready is only ever high in SYNC/DATA, so this is the "stream ran dry" cycle.
    assign O_underflow = O_data_ready & ~I_data_valid;

    always_comb begin
        state_n   = state;
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state)
            ST_IDLE: if (I_hs_req) begin
                state_n = ST_LPX;     tmr_load = 1'b1; tmr_value = LPX_LOAD;
            end
            ST_LPX: if (tmr_done) begin
                state_n = ST_PREP;    tmr_load = 1'b1; tmr_value = PREP_LOAD;
            end
            ST_PREP: if (tmr_done) begin
                state_n = ST_HS_ZERO; tmr_load = 1'b1; tmr_value = ZERO_LOAD;
            end
            ST_HS_ZERO: if (tmr_done) begin
                state_n = ST_SYNC;
            end
            // Without an accepted beat we either just showed the last one
            // (ready was dropped) or the source ran dry; both end the burst.
            ST_SYNC, ST_DATA: begin
                if (accept) begin
                    state_n = ST_DATA;
                end else begin
                    state_n = ST_TRAIL; tmr_load = 1'b1; tmr_value = TRAIL_LOAD;
                end
            end
            ST_TRAIL: if (tmr_done) begin
                state_n = ST_EXIT;    tmr_load = 1'b1; tmr_value = EXIT_LOAD;
            end
            ST_EXIT: if (tmr_done) begin
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Output values for the coming state, registered alongside it.
    always_comb begin
        lptx_valid_n = 1'b1;
        lp_code_n    = LP11;
        hs_en_n      = 1'b0;
        hs_data_n    = '0;
        ready_n      = 1'b0;
        busy_n       = (state_n != ST_IDLE);
        case (state_n)
            ST_LPX:     lp_code_n = LP01;
            ST_PREP:    lp_code_n = LP00;
            ST_HS_ZERO: begin
                lptx_valid_n = 1'b0; lp_code_n = LP00; hs_en_n = 1'b1;
            end
            ST_SYNC: begin
                lptx_valid_n = 1'b0; lp_code_n = LP00; hs_en_n = 1'b1;
                hs_data_n    = {NUM_LANES{SYNC_BYTE}};
                ready_n      = 1'b1;
            end
            // DATA is only entered on an accepted beat; hold off further beats
            // while the last one is on the wire.
            ST_DATA: begin
                lptx_valid_n = 1'b0; lp_code_n = LP00; hs_en_n = 1'b1;
                hs_data_n    = I_data;
                ready_n      = ~I_last;
            end
            ST_TRAIL: begin
                lptx_valid_n = 1'b0; lp_code_n = LP00; hs_en_n = 1'b1;
                hs_data_n    = (state == ST_TRAIL) ? O_hs_data : trail_word(O_hs_data);
            end
            default: ;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state        <= ST_IDLE;
            O_lptx_valid <= 1'b1;
            O_lptx_p     <= 1'b1;
            O_lptx_n     <= 1'b1;
            O_hs_en      <= 1'b0;
            O_hs_data    <= '0;
            O_data_ready <= 1'b0;
            O_busy       <= 1'b0;
        end else begin
            state        <= state_n;
            O_lptx_valid <= lptx_valid_n;
            O_lptx_p     <= lp_code_n[1];
            O_lptx_n     <= lp_code_n[0];
            O_hs_en      <= hs_en_n;
            O_hs_data    <= hs_data_n;
            O_data_ready <= ready_n;
            O_busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_mipi_dphy_tx_lane_ctrl.sv
// tb/tb_mipi_dphy_tx_lane_ctrl.sv - scoreboard bench for the D-PHY TX lane controller
module tb_mipi_dphy_tx_lane_ctrl;

    localparam int T_LPX        = 2;
    localparam int T_HS_PREPARE = 2;
    localparam int T_HS_ZERO    = 6;
    localparam int T_HS_TRAIL   = 3;
    localparam int T_HS_EXIT    = 4;

    logic        I_clk = 1'b0;
    logic        I_rst_n;
    logic        I_hs_req;
    logic [31:0] I_data;
    logic        I_data_valid;
    logic        I_last;
    logic        O_data_ready, O_lptx_valid, O_lptx_p, O_lptx_n, O_hs_en, O_busy, O_underflow;
    logic [31:0] O_hs_data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [38:0] v;   // {lptx_valid, p, n, hs_en, ready, busy, underflow, hs_data}
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] beats[8];

    localparam logic [38:0] RESET_VEC = {7'b1110000, 32'h0};

    mipi_dphy_tx_lane_ctrl #(
        .T_LPX(T_LPX), .T_HS_PREPARE(T_HS_PREPARE), .T_HS_ZERO(T_HS_ZERO),
        .T_HS_TRAIL(T_HS_TRAIL), .T_HS_EXIT(T_HS_EXIT)
    ) dut (
        .I_clk(I_clk), .I_rst_n(I_rst_n), .I_hs_req(I_hs_req), .I_data(I_data),
        .I_data_valid(I_data_valid), .I_last(I_last), .O_data_ready(O_data_ready),
        .O_lptx_valid(O_lptx_valid), .O_lptx_p(O_lptx_p), .O_lptx_n(O_lptx_n),
        .O_hs_en(O_hs_en), .O_hs_data(O_hs_data), .O_busy(O_busy), .O_underflow(O_underflow)
    );

    always #5 I_clk = ~I_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [38:0] observed();
        return {O_lptx_valid, O_lptx_p, O_lptx_n, O_hs_en, O_data_ready, O_busy, O_underflow, O_hs_data};
    endfunction

    task automatic check(input string tag, input logic [38:0] obs, input logic [38:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic void push(input string tag, input logic [6:0] ctl, input logic [31:0] d, input int reps);
        exp_t e;
        for (int i = 0; i < reps; i++) begin
            e.tag = tag;
            e.v   = {ctl, d};
            exp_q.push_back(e);
        end
    endfunction

    function automatic logic [31:0] model_trail(input logic [31:0] w);
        logic [31:0] r;
        r[31:24] = w[31] ? 8'h00 : 8'hFF;
        r[23:16] = w[23] ? 8'h00 : 8'hFF;
        r[15:8]  = w[15] ? 8'h00 : 8'hFF;
        r[7:0]   = w[7]  ? 8'h00 : 8'hFF;
        return r;
    endfunction

    task automatic drive_src(input int idx, input int n, input int n_avail);
        I_data       = (idx < n) ? beats[idx] : 32'hDEADBEEF;
        I_data_valid = (idx < n_avail) && (idx < n);
        I_last       = (idx == n - 1);
    endtask

    // Called at a negedge with the DUT in IDLE. n beats, last on beat n; the
    // source only has n_avail of them. abort_at >= 0 pulses reset after that cycle.
    task automatic run_burst(input string name, input int n, input int n_avail,
                             input bit hold_req, input bit toggle_req, input int abort_at);
        int          sent, idx, pos, busy_cnt;
        bit          acc;
        logic [31:0] shown;
        exp_t        e;

        sent  = (n_avail >= n) ? n : n_avail;
        shown = 32'hB8B8B8B8;
        push("lpx",  7'b1010010, 32'h0, T_LPX);
        push("prep", 7'b1000010, 32'h0, T_HS_PREPARE);
        push("zero", 7'b0001010, 32'h0, T_HS_ZERO);
        push("sync", {5'b00011, 1'b1, sent == 0}, 32'hB8B8B8B8, 1);
        for (int k = 0; k < sent; k++) begin
            push("data", {4'b0001, k != n - 1, 1'b1, (k == sent - 1) && (k != n - 1)}, beats[k], 1);
            shown = beats[k];
        end
        push("trail", 7'b0001010, model_trail(shown), T_HS_TRAIL);
        push("exit",  7'b1110010, 32'h0, T_HS_EXIT);
        push("idle",  7'b1110000, 32'h0, 1);

        idx = 0; pos = 0; busy_cnt = 0; acc = 1'b0;
        I_hs_req = 1'b1;
        drive_src(idx, n, n_avail);
        while (exp_q.size() > 0) begin
            @(posedge I_clk); #1;
            if (acc) idx++;
            if (toggle_req)     I_hs_req = (exp_q.size() > 1) ? ~I_hs_req : 1'b0;
            else if (!hold_req) I_hs_req = 1'b0;
            drive_src(idx, n, n_avail);
            @(negedge I_clk);
            e = exp_q.pop_front();
            check($sformatf("%s[%0d] %s", name, pos, e.tag), observed(), e.v);
            if (O_busy) busy_cnt++;
            acc = O_data_ready && I_data_valid;
            if (pos == abort_at) begin
                #2 I_rst_n = 1'b0;
                #1 check($sformatf("%s async reset", name), observed(), RESET_VEC);
                exp_q.delete();
                return;
            end
            pos++;
        end
        check($sformatf("%s busy cycles", name), 39'(busy_cnt),
              39'(T_LPX + T_HS_PREPARE + T_HS_ZERO + 1 + sent + T_HS_TRAIL + T_HS_EXIT));
    endtask

    initial begin
        I_rst_n = 1'b1; I_hs_req = 1'b0; I_data = '0; I_data_valid = 1'b0; I_last = 1'b0;
        #2 I_rst_n = 1'b0;
        #1 check("reset asserted", observed(), RESET_VEC);
        repeat (3) @(posedge I_clk);
        @(negedge I_clk) I_rst_n = 1'b1;
        @(negedge I_clk) check("idle after reset", observed(), RESET_VEC);

        // Nominal 4-beat burst, last beats all have bit7=0 -> trail all ones
        beats[0] = 32'h01020304; beats[1] = 32'h05060708;
        beats[2] = 32'h090A0B0C; beats[3] = 32'h0D0E0F10;
        run_burst("four_beats", 4, 4, 1'b0, 1'b0, -1);

        // Single beat accepted in SYNC, all bit7 set -> trail zeros
        beats[0] = 32'h80808080;
        run_burst("one_beat", 1, 1, 1'b0, 1'b0, -1);

        // Mixed lanes in the last beat
        beats[0] = 32'h11223344; beats[1] = 32'h807F00FF;
        run_burst("mixed_trail", 2, 2, 1'b0, 1'b0, -1);

        // No data at SYNC -> underflow, trail from sync byte
        beats[0] = 32'hAAAA5555;
        run_burst("underflow_sync", 3, 0, 1'b0, 1'b0, -1);

        // Valid drops after beat 2 of 5
        beats[0] = 32'hCAFEF00D; beats[1] = 32'h1192_33F4; beats[2] = 32'h0;
        beats[3] = 32'h0; beats[4] = 32'h0;
        run_burst("underflow_data", 5, 2, 1'b0, 1'b0, -1);

        // Request held across two bursts, second with request toggling mid-burst
        beats[0] = 32'h0A0B0C0D; beats[1] = 32'hF0E0D0C0; beats[2] = 32'h7F7F8080;
        run_burst("held_a", 3, 3, 1'b1, 1'b0, -1);
        beats[0] = 32'h13579BDF; beats[1] = 32'h2468ACE0;
        run_burst("held_b", 2, 2, 1'b0, 1'b1, -1);

        // Reset in the middle of DATA
        beats[0] = 32'h55AA55AA; beats[1] = 32'hAA55AA55; beats[2] = 32'h12345678;
        run_burst("abort", 3, 3, 1'b0, 1'b0, T_LPX + T_HS_PREPARE + T_HS_ZERO + 2);
        @(posedge I_clk); #1 check("held in reset", observed(), RESET_VEC);
        @(negedge I_clk) I_rst_n = 1'b1;
        @(negedge I_clk) check("idle after abort", observed(), RESET_VEC);
        beats[0] = 32'h01234567; beats[1] = 32'h89ABCDEF;
        run_burst("after_abort", 2, 2, 1'b0, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
